// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, column/state types and the xtime helper
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;
    localparam int         AES_NB   = 4;

    // Byte 3 is row 0 (the MSB byte of a column on the bus).
    typedef logic [3:0][7:0] col_t;
    // Element AES_NB-1 is column 0 (the MSB word of the state on the bus).
    typedef col_t [AES_NB-1:0] state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_col_unit.sv
// rtl/mix_col_unit.sv - combinational MixColumns / InvMixColumns on one 32-bit column
module mix_col_unit
    import aes_pkg::*;
(
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] result
);

    col_t       a;
    col_t       p;
    logic [7:0] u;
    logic [7:0] v;
    logic [7:0] t;

    assign a = col;

    // The inverse is a cheap pre-mix folded into the forward transform.
    assign u = xtime(xtime(a[3] ^ a[1]));
    assign v = xtime(xtime(a[2] ^ a[0]));
    assign p = inv ? {a[3] ^ u, a[2] ^ v, a[1] ^ u, a[0] ^ v} : a;

    assign t = p[3] ^ p[2] ^ p[1] ^ p[0];

    assign result = {p[3] ^ t ^ xtime(p[3] ^ p[2]),
                     p[2] ^ t ^ xtime(p[2] ^ p[1]),
                     p[1] ^ t ^ xtime(p[1] ^ p[0]),
                     p[0] ^ t ^ xtime(p[0] ^ p[3])};

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential MixColumns engine with valid/ready handshakes
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int NB             = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         inv_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (NB != AES_NB) begin : g_bad_nb
        $error("mix_columns_seq: NB must be 4");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(NB - COLS_PER_CYCLE);

    logic [1:0] fsm_q;
    logic [1:0] col_cnt;
    logic       mode_q;
    state_t     state_q;
    state_t     state_nxt;
    logic       accept;

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_res [COLS_PER_CYCLE];

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign col_idx[k] = col_cnt + 2'(k);

        // Column c lives at state_q[3-c], i.e. state_q[~c] for a 2-bit index.
        mix_col_unit u_mix (
            .col    (state_q[~col_idx[k]]),
            .inv    (mode_q),
            .result (col_res[k])
        );
    end

    always_comb begin
        state_nxt = state_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            state_nxt[~col_idx[k]] = col_res[k];
        end
    end

    assign in_ready  = (fsm_q == IDLE) || (fsm_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == BUSY);
    assign out_data  = (fsm_q == DONE) ? state_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            col_cnt <= 2'd0;
            mode_q  <= 1'b0;
            state_q <= '0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= in_data;
                        mode_q  <= inv_en;
                        col_cnt <= 2'd0;
                        fsm_q   <= BUSY;
                    end else if (fsm_q == DONE && out_ready) begin
                        fsm_q <= IDLE;
                    end
                end
                BUSY: begin
                    state_q <= state_nxt;
                    col_cnt <= col_cnt + STEP;
                    if (col_cnt == LAST_CNT) begin
                        fsm_q <= DONE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - directed and randomised checks of mix_columns_seq for 1, 2 and 4 columns per cycle
module tb_mix_columns_seq;

    localparam logic [127:0] PLAIN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] MIXED  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] PLAIN2 = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] MIXED2 = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic         inv_en;
    logic [2:0]   in_valid_a;
    logic [2:0]   out_ready_a;
    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic         busy_w      [3];
    logic [127:0] out_data_w  [3];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1), .NB(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_w[0]),
        .in_data(in_data), .inv_en(inv_en), .out_valid(out_valid_w[0]),
        .out_ready(out_ready_a[0]), .out_data(out_data_w[0]), .busy(busy_w[0]));

    mix_columns_seq #(.COLS_PER_CYCLE(2), .NB(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_w[1]),
        .in_data(in_data), .inv_en(inv_en), .out_valid(out_valid_w[1]),
        .out_ready(out_ready_a[1]), .out_data(out_data_w[1]), .busy(busy_w[1]));

    mix_columns_seq #(.COLS_PER_CYCLE(4), .NB(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_w[2]),
        .in_data(in_data), .inv_en(inv_en), .out_valid(out_valid_w[2]),
        .out_ready(out_ready_a[2]), .out_data(out_data_w[2]), .busy(busy_w[2]));

    // Reference uses textbook GF(2^8) multiplication by the matrix constants.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 32*c - 8*r -: 8];
            if (inv) begin
                m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
            end else begin
                m = '{8'h02, 8'h03, 8'h01, 8'h01};
            end
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = gmul(a[r], m[0]) ^ gmul(a[(r+1)%4], m[1])
                                         ^ gmul(a[(r+2)%4], m[2]) ^ gmul(a[(r+3)%4], m[3]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one block into an idle engine and collects its result.
    task automatic run_block(input int k, input logic [127:0] d, input logic inv,
                             output logic [127:0] res, output int nbusy, output bit timeout);
        int n;
        nbusy = 0;
        n = 0;
        @(negedge clk);
        in_valid_a[k]  = 1'b1;
        in_data        = d;
        inv_en         = inv;
        out_ready_a[k] = 1'b0;
        @(negedge clk);
        in_valid_a[k] = 1'b0;
        in_data       = rand128();
        inv_en        = ~inv;
        while (!out_valid_w[k] && n < 20) begin
            if (busy_w[k]) nbusy++;
            @(negedge clk);
            n++;
        end
        timeout = !out_valid_w[k];
        res = out_data_w[k];
        out_ready_a[k] = 1'b1;
        @(negedge clk);
        out_ready_a[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks += 4;
            if (out_valid_w[k] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", k, out_valid_w[k]);
            end
            if (out_data_w[k] !== 128'h0) begin
                errors++; $display("FAIL reset_out_data dut%0d: got %h expected 0", k, out_data_w[k]);
            end
            if (busy_w[k] !== 1'b0) begin
                errors++; $display("FAIL reset_busy dut%0d: got %b expected 0", k, busy_w[k]);
            end
            if (in_ready_w[k] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready dut%0d: got %b expected 1", k, in_ready_w[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        logic [127:0] res;
        int nb;
        bit to;
        run_block(0, PLAIN, 1'b0, res, nb, to);
        checks += 3;
        if (to) begin errors++; $display("FAIL fwd_timeout: out_valid never rose"); end
        if (nb != 4) begin errors++; $display("FAIL fwd_latency: got %0d busy cycles expected 4", nb); end
        if (res !== MIXED) begin errors++; $display("FAIL fwd_data: got %h expected %h", res, MIXED); end
    endtask

    task automatic test_inverse();
        logic [127:0] res;
        int nb;
        bit to;
        for (int k = 0; k < 3; k++) begin
            run_block(k, MIXED, 1'b1, res, nb, to);
            checks += 3;
            if (to) begin errors++; $display("FAIL inv_timeout dut%0d: out_valid never rose", k); end
            if (nb != (4 >> k)) begin
                errors++; $display("FAIL inv_latency dut%0d: got %0d expected %0d", k, nb, 4 >> k);
            end
            if (res !== PLAIN) begin
                errors++; $display("FAIL inv_data dut%0d: got %h expected %h", k, res, PLAIN);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_data = PLAIN;
        inv_en = 1'b0;
        out_ready_a[0] = 1'b0;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        while (!out_valid_w[0] && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!out_valid_w[0]) begin errors++; $display("FAIL bp_timeout: out_valid never rose"); end
        for (int i = 0; i < 10; i++) begin
            in_data = rand128();
            #1;
            checks += 3;
            if (out_valid_w[0] !== 1'b1) begin
                errors++; $display("FAIL bp_hold_valid cycle %0d: got %b expected 1", i, out_valid_w[0]);
            end
            if (out_data_w[0] !== MIXED) begin
                errors++; $display("FAIL bp_hold_data cycle %0d: got %h expected %h", i, out_data_w[0], MIXED);
            end
            if (in_ready_w[0] !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready_w[0]);
            end
            @(negedge clk);
        end
        out_ready_a[0] = 1'b1;
        #1;
        checks++;
        if (in_ready_w[0] !== 1'b1) begin
            errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready_w[0]);
        end
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid_w[0] !== 1'b0) begin
                errors++; $display("FAIL bp_single_transfer cycle %0d: out_valid got %b expected 0", i, out_valid_w[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_data = PLAIN;
        inv_en = 1'b0;
        out_ready_a[0] = 1'b0;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        while (!out_valid_w[0] && n < 20) begin @(negedge clk); n++; end
        in_valid_a[0] = 1'b1;
        in_data = PLAIN2;
        inv_en = 1'b0;
        out_ready_a[0] = 1'b1;
        #1;
        checks += 2;
        if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready_w[0]); end
        if (out_data_w[0] !== MIXED) begin errors++; $display("FAIL b2b_first: got %h expected %h", out_data_w[0], MIXED); end
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        out_ready_a[0] = 1'b0;
        checks++;
        if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL b2b_accepted: busy got %b expected 1", busy_w[0]); end
        n = 0;
        while (!out_valid_w[0] && n < 20) begin @(negedge clk); n++; end
        checks += 3;
        if (out_data_w[0][127:96] !== 32'hd5d5d7d6) begin
            errors++; $display("FAIL b2b_col0: got %h expected d5d5d7d6", out_data_w[0][127:96]);
        end
        if (out_data_w[0][95:64] !== 32'h4d7ebdf8) begin
            errors++; $display("FAIL b2b_col1: got %h expected 4d7ebdf8", out_data_w[0][95:64]);
        end
        if (out_data_w[0] !== MIXED2) begin
            errors++; $display("FAIL b2b_second: got %h expected %h", out_data_w[0], MIXED2);
        end
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
    endtask

    task automatic test_reset_mid_block();
        logic [127:0] res;
        int nb;
        bit to;
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_data = PLAIN;
        inv_en = 1'b0;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid_w[0]); end
        if (out_data_w[0] !== 128'h0) begin errors++; $display("FAIL mid_rst_out_data: got %h expected 0", out_data_w[0]); end
        if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready_w[0]); end
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy_w[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (out_valid_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_discard: out_valid got %b expected 0", out_valid_w[0]); end
        end
        run_block(0, PLAIN2, 1'b0, res, nb, to);
        checks++;
        if (to || res !== MIXED2) begin
            errors++; $display("FAIL mid_rst_next_block: got %h expected %h timeout=%0d", res, MIXED2, to);
        end
    endtask

    task automatic test_random(input int k, input int nblocks);
        logic [127:0] exp_q [$];
        logic [127:0] exp;
        int accepted;
        int cycles;
        accepted = 0;
        cycles = 0;
        while ((accepted < nblocks || exp_q.size() != 0) && cycles < 40000) begin
            @(negedge clk);
            in_valid_a[k]  = (accepted < nblocks) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data        = rand128();
            inv_en         = 1'($urandom_range(0, 1));
            out_ready_a[k] = 1'($urandom_range(0, 3) != 0);
            #1;
            if (in_valid_a[k] && in_ready_w[k]) begin
                exp_q.push_back(ref_mix(in_data, inv_en));
                accepted++;
            end
            if (out_valid_w[k] && out_ready_a[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected dut%0d: got %h with no block pending", k, out_data_w[k]);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data_w[k] !== exp) begin
                        errors++; $display("FAIL rand_data dut%0d: got %h expected %h", k, out_data_w[k], exp);
                    end
                end
            end
            cycles++;
        end
        checks++;
        if (accepted < nblocks || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_timeout dut%0d: accepted %0d of %0d, %0d pending", k, accepted, nblocks, exp_q.size());
        end
        @(negedge clk);
        in_valid_a[k]  = 1'b0;
        out_ready_a[k] = 1'b1;
        @(negedge clk);
        out_ready_a[k] = 1'b0;
    endtask

    task automatic test_roundtrip();
        logic [127:0] orig;
        logic [127:0] fwd;
        logic [127:0] back;
        int nb;
        bit to1;
        bit to2;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                orig = rand128();
                run_block(k, orig, 1'b0, fwd, nb, to1);
                run_block(k, fwd, 1'b1, back, nb, to2);
                checks++;
                if (to1 || to2 || back !== orig) begin
                    errors++; $display("FAIL roundtrip dut%0d: got %h expected %h", k, back, orig);
                end
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_valid_a  = 3'b000;
        out_ready_a = 3'b000;
        in_data     = '0;
        inv_en      = 1'b0;
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        test_random(0, 1000);
        test_random(1, 200);
        test_random(2, 200);
        test_roundtrip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
Sequential, parametrised MixColumns / InvMixColumns engine that operates on a full 128-bit AES state. It sits between the ShiftRows and AddRoundKey stages of the round datapath. A valid/ready handshake on each side lets the round controller stall it. Each cycle it processes COLS_PER_CYCLE columns, and it supports both forward and inverse transforms, selected per block.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2 or 4; any other value is an elaboration error.
NB, 4, columns per state; fixed at 4 (AES); exposed only for derived widths.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  a state block is presented on in_data.
in_ready  output  1  engine can accept a block this cycle.
in_data  input  128  input state; column c = bits [127-32c : 96-32c]; row 0 is the MSB byte of each column.
inv_en  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data.
out_valid  output  1  out_data holds a finished block.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  128  transformed state, same layout as in_data.
busy  output  1  high in BUSY state.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; col_cnt=0; out_valid=0; out_data=0; busy=0; in_ready=1. The internal state register and mode register clear to 0.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: in_ready=1. If in_valid, latch in_data into the state register and inv_en into the mode register, set col_cnt=0, and go to BUSY.
  - BUSY: each cycle, replace columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in place with their transformed values, then col_cnt += COLS_PER_CYCLE. On the cycle that processes the last column, go to DONE.
  - DONE: out_valid=1 and out_data=the state register.
    - On out_ready with in_valid: accept a new block in the same cycle (in_ready=1 in DONE only when out_ready=1) and go to BUSY.
    - On out_ready without in_valid: go to IDLE.
    - Without out_ready: hold, with out_data stable.
- Latency: NB/COLS_PER_CYCLE BUSY cycles (4, 2 or 1) from the accepting edge, after which out_valid asserts on the next edge. Peak throughput is one block per NB/COLS_PER_CYCLE+1 cycles.
- in_data and inv_en are ignored outside the accept cycle. The mode is fixed per block.
- col_cnt is 2 bits and wraps from 3 to 0. It is reset to 0 on every accept.
- Column transform, with GF(2^8) reduction polynomial 0x11b and xtime(a) = (a<<1) ^ (a[7] ? 0x1b : 0):
  - Forward: t = a0^a1^a2^a3; bi = ai ^ t ^ xtime(ai ^ a(i+1 mod 4)).
  - Inverse: u = xtime(xtime(a0^a2)); v = xtime(xtime(a1^a3)); pre-mix a0^=u, a1^=v, a2^=u, a3^=v; then apply the forward transform.
  - Both transforms are purely combinational within one cycle per column.
- rst_n asserted mid-block: the block is discarded and no output is produced. After release the engine is in IDLE.
- out_valid never deasserts without an out_ready handshake.

Decomposition:
- Shared package aes_pkg holds AES_POLY=8'h1b, AES_NB=4, the column typedef (four 8-bit bytes) and the state typedef (NB columns). The existing xtime function or module is reused from there.
- Sub-module mix_col_unit: one 32-bit column with a 1-bit inv input, combinational; the top level instantiates COLS_PER_CYCLE copies. The top level contains only the FSM, the counter, column muxing and the registers.

Test Plan:
1. Forward, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_c6c6c6c6, inv_en=0 -> after 4 BUSY cycles out_valid=1 and out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
2. Inverse, for each COLS_PER_CYCLE in {1,2,4}: in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv_en=1 -> out_data=db135345_f20a225c_01010101_c6c6c6c6 after 4, 2 and 1 BUSY cycles respectively.
3. Backpressure: run scenario 1 with out_ready=0 for 10 cycles -> out_valid stays high and out_data is stable; in_ready=0 throughout; release out_ready -> exactly one transfer.
4. Back-to-back: in DONE with out_ready=1 and in_valid=1 (d4d4d4d5_2d26314c_…, inv_en=0) -> new block accepted in the same cycle; second result has column 0 = d5d5d7d6 and column 1 = 4d7ebdf8.
5. Reset mid-block: assert rst_n=0 during the second BUSY cycle -> out_valid=0, out_data=0, in_ready=1 immediately; the next block completes correctly.
6. Random: 1000 random states with random inv_en, out_ready and in_valid -> matches the reference model; forward followed by inverse returns the original state.
